// File: rtl/m_mc_ctrl.sv
// Multi-cycle RV32I control FSM sequencing one shared ALU and one unified memory.
// Optional performance counters are enabled by defining MC_CTRL_PERF_CNT_EN.
module m_mc_ctrl #(
   parameter bit ILLEGAL_HALT = 1'b1,
   parameter int CNT_W        = 32
) (
   input  logic             w_clk,
   input  logic             w_rst,
   input  logic [6:0]       w_opcode,
   input  logic             w_alu_zero,
   input  logic             w_mem_ready,
   output logic             w_pc_write,
   output logic             w_adr_src,
   output logic             w_mem_write,
   output logic             w_ir_write,
   output logic             w_reg_write,
   output logic [1:0]       w_alu_src_a,
   output logic [1:0]       w_alu_src_b,
   output logic [1:0]       w_alu_op,
   output logic [1:0]       w_result_src,
   output logic             w_retire,
   output logic             w_halted,
   output logic [3:0]       w_state,
   output logic [CNT_W-1:0] w_cycle_cnt,
   output logic [CNT_W-1:0] w_inst_cnt
);

   // state    | meaning
   // FETCH    | read instruction at PC, PC <= PC+4 on ready
   // DECODE   | read registers, compute branch/jump target
   // MEMADR   | compute load/store address
   // MEMREAD  | load access, wait for ready
   // MEMWB    | write load data to register file
   // MEMWRITE | store access, wait for ready
   // EXECR    | R-type ALU operation
   // ALUWB    | write ALU result to register file
   // EXECI    | I-type ALU operation
   // JAL      | PC <= target, compute link address
   // BEQ      | compare operands, branch on zero
   // HALT     | unsupported opcode, sticky until reset
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_HALT     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   state_t state;

   logic pc_write_raw;
   logic mem_write_raw;
   logic ir_write_raw;
   logic reg_write_raw;
   logic retire_raw;

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:    if (w_mem_ready) state <= S_DECODE;
            S_DECODE: begin
               case (w_opcode)
                  OP_LW, OP_SW: state <= S_MEMADR;
                  OP_R:         state <= S_EXECR;
                  OP_I:         state <= S_EXECI;
                  OP_JAL:       state <= S_JAL;
                  OP_BEQ:       state <= S_BEQ;
                  default:      state <= ILLEGAL_HALT ? S_HALT : S_FETCH;
               endcase
            end
            S_MEMADR:   state <= (w_opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (w_mem_ready) state <= S_MEMWB;
            S_MEMWB:    state <= S_FETCH;
            S_MEMWRITE: if (w_mem_ready) state <= S_FETCH;
            S_EXECR:    state <= S_ALUWB;
            S_EXECI:    state <= S_ALUWB;
            S_ALUWB:    state <= S_FETCH;
            S_JAL:      state <= S_ALUWB;
            S_BEQ:      state <= S_FETCH;
            S_HALT:     state <= S_HALT;
            default:    state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      pc_write_raw  = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      retire_raw    = 1'b0;
      w_adr_src     = 1'b0;
      w_alu_src_a   = 2'b00;
      w_alu_src_b   = 2'b00;
      w_alu_op      = 2'b00;
      w_result_src  = 2'b00;
      w_halted      = 1'b0;
      case (state)
         S_FETCH: begin
            w_alu_src_b  = 2'b10;
            w_result_src = 2'b10;
            ir_write_raw = w_mem_ready;
            pc_write_raw = w_mem_ready;
         end
         S_DECODE: begin
            w_alu_src_a = 2'b01;
            w_alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            w_alu_src_a = 2'b10;
            w_alu_src_b = 2'b01;
         end
         S_MEMREAD: w_adr_src = 1'b1;
         S_MEMWB: begin
            w_result_src  = 2'b01;
            reg_write_raw = 1'b1;
            retire_raw    = 1'b1;
         end
         S_MEMWRITE: begin
            w_adr_src     = 1'b1;
            mem_write_raw = 1'b1;
            retire_raw    = w_mem_ready;
         end
         S_EXECR: begin
            w_alu_src_a = 2'b10;
            w_alu_op    = 2'b10;
         end
         S_EXECI: begin
            w_alu_src_a = 2'b10;
            w_alu_src_b = 2'b01;
            w_alu_op    = 2'b10;
         end
         S_ALUWB: begin
            reg_write_raw = 1'b1;
            retire_raw    = 1'b1;
         end
         S_JAL: begin
            w_alu_src_a  = 2'b01;
            w_alu_src_b  = 2'b10;
            pc_write_raw = 1'b1;
         end
         S_BEQ: begin
            w_alu_src_a  = 2'b10;
            w_alu_op     = 2'b01;
            pc_write_raw = w_alu_zero;
            retire_raw   = 1'b1;
         end
         S_HALT:  w_halted = 1'b1;
         default: ;
      endcase
   end

   // Reset kills every strobe in the same cycle so an in-flight access aborts cleanly.
   assign w_pc_write  = pc_write_raw  & ~w_rst;
   assign w_mem_write = mem_write_raw & ~w_rst;
   assign w_ir_write  = ir_write_raw  & ~w_rst;
   assign w_reg_write = reg_write_raw & ~w_rst;
   assign w_retire    = retire_raw    & ~w_rst;
   assign w_state     = state;

`ifdef MC_CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] inst_cnt;

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         cycle_cnt <= '0;
         inst_cnt  <= '0;
      end else begin
         if (state != S_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (w_retire)        inst_cnt  <= inst_cnt + CNT_W'(1);
      end
   end

   assign w_cycle_cnt = cycle_cnt;
   assign w_inst_cnt  = inst_cnt;
`else
   assign w_cycle_cnt = '0;
   assign w_inst_cnt  = '0;
`endif

endmodule

// File: tb/tb_m_mc_ctrl.sv
// Directed testbench for m_mc_ctrl; expected values are hand-derived per instruction sequence.
module tb_m_mc_ctrl;
   localparam int CNT_W = 32;

   logic             w_clk = 1'b0;
   logic             w_rst = 1'b1;
   logic [6:0]       w_opcode = 7'b0;
   logic             w_alu_zero = 1'b0;
   logic             w_mem_ready = 1'b0;
   logic             w_pc_write, w_adr_src, w_mem_write, w_ir_write, w_reg_write;
   logic [1:0]       w_alu_src_a, w_alu_src_b, w_alu_op, w_result_src;
   logic             w_retire, w_halted;
   logic [3:0]       w_state;
   logic [CNT_W-1:0] w_cycle_cnt, w_inst_cnt;

   int n_vec = 0;
   int n_err = 0;

   m_mc_ctrl #(.ILLEGAL_HALT(1'b1), .CNT_W(CNT_W)) dut (
      .w_clk(w_clk), .w_rst(w_rst), .w_opcode(w_opcode), .w_alu_zero(w_alu_zero),
      .w_mem_ready(w_mem_ready), .w_pc_write(w_pc_write), .w_adr_src(w_adr_src),
      .w_mem_write(w_mem_write), .w_ir_write(w_ir_write), .w_reg_write(w_reg_write),
      .w_alu_src_a(w_alu_src_a), .w_alu_src_b(w_alu_src_b), .w_alu_op(w_alu_op),
      .w_result_src(w_result_src), .w_retire(w_retire), .w_halted(w_halted),
      .w_state(w_state), .w_cycle_cnt(w_cycle_cnt), .w_inst_cnt(w_inst_cnt)
   );

   always #5 w_clk = ~w_clk;

   // Layout: pc_write adr_src mem_write ir_write reg_write src_a src_b alu_op result_src retire halted
   function automatic logic [14:0] sig();
      return {w_pc_write, w_adr_src, w_mem_write, w_ir_write, w_reg_write,
              w_alu_src_a, w_alu_src_b, w_alu_op, w_result_src, w_retire, w_halted};
   endfunction

   task automatic cyc();
      @(posedge w_clk);
      #1;
   endtask

   task automatic test_reset();
      w_rst = 1'b1;
      w_mem_ready = 1'b1;
      w_opcode = 7'b0000011;
      cyc();
      cyc();
      #1;
      n_vec++;
      if (w_state !== 4'd0) begin
         n_err++; $display("FAIL reset_state: got %0d want 0", w_state);
      end
      n_vec++;
      if (sig() !== 15'b0_0_0_0_0_00_10_00_10_0_0) begin
         n_err++; $display("FAIL reset_strobes: got %b want %b", sig(), 15'b0_0_0_0_0_00_10_00_10_0_0);
      end
      n_vec++;
      if (w_cycle_cnt !== '0 || w_inst_cnt !== '0) begin
         n_err++; $display("FAIL reset_counters: got %0d/%0d want 0/0", w_cycle_cnt, w_inst_cnt);
      end
   endtask

   task automatic test_lw();
      logic [3:0]  est [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      logic [14:0] esg [5] = '{15'b1_0_0_1_0_00_10_00_10_0_0,
                              15'b0_0_0_0_0_01_01_00_00_0_0,
                              15'b0_0_0_0_0_10_01_00_00_0_0,
                              15'b0_1_0_0_0_00_00_00_00_0_0,
                              15'b0_0_0_0_1_00_00_00_01_1_0};
      w_rst = 1'b0;
      w_mem_ready = 1'b1;
      w_opcode = 7'b0000011;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_vec++;
         if (w_state !== est[i] || sig() !== esg[i]) begin
            n_err++; $display("FAIL lw_c%0d: got st=%0d sig=%b want st=%0d sig=%b", i+1, w_state, sig(), est[i], esg[i]);
         end
         cyc();
      end
      n_vec++;
      if (w_state !== 4'd0) begin
         n_err++; $display("FAIL lw_end: got %0d want 0", w_state);
      end
   endtask

   task automatic test_sw_stall();
      logic [3:0]  est [6] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5};
      logic        rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [14:0] esg [6] = '{15'b1_0_0_1_0_00_10_00_10_0_0,
                              15'b0_0_0_0_0_01_01_00_00_0_0,
                              15'b0_0_0_0_0_10_01_00_00_0_0,
                              15'b0_1_1_0_0_00_00_00_00_0_0,
                              15'b0_1_1_0_0_00_00_00_00_0_0,
                              15'b0_1_1_0_0_00_00_00_00_1_0};
      w_opcode = 7'b0100011;
      for (int i = 0; i < 6; i++) begin
         w_mem_ready = rdy[i];
         #1;
         n_vec++;
         if (w_state !== est[i] || sig() !== esg[i]) begin
            n_err++; $display("FAIL sw_c%0d: got st=%0d sig=%b want st=%0d sig=%b", i+1, w_state, sig(), est[i], esg[i]);
         end
         cyc();
      end
      w_mem_ready = 1'b1;
      n_vec++;
      if (w_state !== 4'd0) begin
         n_err++; $display("FAIL sw_end: got %0d want 0", w_state);
      end
   endtask

   task automatic test_beq();
      logic [14:0] e_bq;
      for (int z = 1; z >= 0; z--) begin
         w_opcode = 7'b1100011;
         w_alu_zero = z[0];
         w_mem_ready = 1'b1;
         e_bq = z[0] ? 15'b1_0_0_0_0_10_00_01_00_1_0 : 15'b0_0_0_0_0_10_00_01_00_1_0;
         cyc();
         cyc();
         #1;
         n_vec++;
         if (w_state !== 4'd10 || sig() !== e_bq) begin
            n_err++; $display("FAIL beq_z%0d: got st=%0d sig=%b want st=10 sig=%b", z, w_state, sig(), e_bq);
         end
         cyc();
         n_vec++;
         if (w_state !== 4'd0) begin
            n_err++; $display("FAIL beq_z%0d_end: got %0d want 0", z, w_state);
         end
      end
      w_alu_zero = 1'b0;
   endtask

   task automatic test_alu_jal();
      logic [6:0]  ops [3] = '{7'b0110011, 7'b0010011, 7'b1101111};
      logic [3:0]  exs [3] = '{4'd6, 4'd8, 4'd9};
      logic [14:0] exg [3] = '{15'b0_0_0_0_0_10_00_10_00_0_0,
                              15'b0_0_0_0_0_10_01_10_00_0_0,
                              15'b1_0_0_0_0_01_10_00_00_0_0};
      w_mem_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         w_opcode = ops[k];
         cyc();
         cyc();
         #1;
         n_vec++;
         if (w_state !== exs[k] || sig() !== exg[k]) begin
            n_err++; $display("FAIL exec_%0d: got st=%0d sig=%b want st=%0d sig=%b", k, w_state, sig(), exs[k], exg[k]);
         end
         cyc();
         #1;
         n_vec++;
         if (w_state !== 4'd7 || sig() !== 15'b0_0_0_0_1_00_00_00_00_1_0) begin
            n_err++; $display("FAIL aluwb_%0d: got st=%0d sig=%b want st=7 sig=%b", k, w_state, sig(), 15'b0_0_0_0_1_00_00_00_00_1_0);
         end
         cyc();
      end
   endtask

   task automatic test_illegal_halt();
      logic bad;
      w_opcode = 7'b1110011;
      w_mem_ready = 1'b1;
      cyc();
      cyc();
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (w_state !== 4'd11 || sig() !== 15'b0_0_0_0_0_00_00_00_00_0_1) bad = 1'b1;
         cyc();
      end
      n_vec++;
      if (bad) begin
         n_err++; $display("FAIL halt_sticky: got st=%0d sig=%b want st=11 sig=%b", w_state, sig(), 15'b0_0_0_0_0_00_00_00_00_0_1);
      end
      w_rst = 1'b1;
      cyc();
      w_rst = 1'b0;
      w_mem_ready = 1'b0;
      #1;
      n_vec++;
      if (w_state !== 4'd0 || w_halted !== 1'b0) begin
         n_err++; $display("FAIL halt_reset: got st=%0d halted=%b want st=0 halted=0", w_state, w_halted);
      end
   endtask

   task automatic test_reset_mid_store();
      w_opcode = 7'b0100011;
      w_mem_ready = 1'b1;
      cyc();
      cyc();
      cyc();
      w_mem_ready = 1'b0;
      #1;
      n_vec++;
      if (w_state !== 4'd5 || w_mem_write !== 1'b1) begin
         n_err++; $display("FAIL stall_pre: got st=%0d mw=%b want st=5 mw=1", w_state, w_mem_write);
      end
      w_rst = 1'b1;
      #1;
      n_vec++;
      if (w_mem_write !== 1'b0 || w_retire !== 1'b0) begin
         n_err++; $display("FAIL stall_rst_same: got mw=%b ret=%b want 0/0", w_mem_write, w_retire);
      end
      cyc();
      w_mem_ready = 1'b1;
      #1;
      n_vec++;
      if (w_state !== 4'd0 || {w_pc_write, w_ir_write, w_mem_write, w_reg_write, w_retire} !== 5'b0) begin
         n_err++; $display("FAIL stall_rst_after: got st=%0d strobes=%b want st=0 strobes=00000", w_state,
            {w_pc_write, w_ir_write, w_mem_write, w_reg_write, w_retire});
      end
   endtask

   task automatic test_perf_cnt();
      logic [CNT_W-1:0] exp_c, exp_i;
`ifdef MC_CTRL_PERF_CNT_EN
      exp_c = 13; exp_i = 3;
`else
      exp_c = 0;  exp_i = 0;
`endif
      w_rst = 1'b1;
      w_mem_ready = 1'b1;
      cyc();
      w_rst = 1'b0;
      for (int i = 0; i < 13; i++) begin
         w_opcode = (i < 4) ? 7'b0110011 : (i < 8) ? 7'b0010011 : 7'b0000011;
         cyc();
      end
      #1;
      n_vec++;
      if (w_state !== 4'd0) begin
         n_err++; $display("FAIL perf_state: got %0d want 0", w_state);
      end
      n_vec++;
      if (w_inst_cnt !== exp_i) begin
         n_err++; $display("FAIL perf_inst: got %0d want %0d", w_inst_cnt, exp_i);
      end
      n_vec++;
      if (w_cycle_cnt !== exp_c) begin
         n_err++; $display("FAIL perf_cycle: got %0d want %0d", w_cycle_cnt, exp_c);
      end
   endtask

   initial begin
      cyc();
      test_reset();
      test_lw();
      test_sw_stall();
      test_beq();
      test_alu_jal();
      test_illegal_halt();
      test_reset_mid_store();
      test_perf_cnt();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/m_mc_ctrl.md
Name: m_mc_ctrl

Overview:
Multi-cycle control FSM for the RV32I datapath. One ALU and one unified instruction/data memory are shared across instruction phases, and this block sequences them. It decodes the latched IR opcode and emits mux selects, ALU op class and write strobes each cycle, stalling on a memory ready handshake. Its ALU op output feeds the existing ALU decoder unchanged.

Parameters:
ILLEGAL_HALT, 1, 1: unsupported opcode enters sticky HALT; 0: treated as NOP (return to FETCH)
CNT_W, 32, width of performance counters

Ports:
w_clk  in  1  clock; one clock domain
w_rst  in  1  reset; synchronous, active-high
w_opcode  in  7  IR[6:0], stable from DECODE onward
w_alu_zero  in  1  ALU zero flag
w_mem_ready  in  1  memory completes access this cycle
w_pc_write  out  1  PC register enable
w_adr_src  out  1  memory address mux: 0=PC, 1=ALU result register
w_mem_write  out  1  memory write request
w_ir_write  out  1  IR and oldPC load enable
w_reg_write  out  1  register file write enable
w_alu_src_a  out  2  ALU operand A: 00=PC, 01=oldPC, 10=rs1
w_alu_src_b  out  2  ALU operand B: 00=rs2, 01=imm, 10=4
w_alu_op  out  2  00=add, 01=sub (beq), 10=funct-decoded
w_result_src  out  2  result mux: 00=ALU result register, 01=memory data register, 10=ALU output
w_retire  out  1  one-cycle pulse when an instruction completes
w_halted  out  1  FSM is in HALT
w_state  out  4  current state, for debug
w_cycle_cnt  out  CNT_W  cycle counter (optional feature)
w_inst_cnt  out  CNT_W  retired-instruction counter (optional feature)

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, HALT=11. State is registered; outputs are Moore-decoded from state, qualified by w_mem_ready where noted.
- Reset: on the edge where w_rst=1, state becomes FETCH and counters clear. While w_rst=1, all strobes are forced to 0: pc_write, mem_write, ir_write, reg_write and retire. Reset in any state, including mid-MEMWRITE or mid-stall, aborts the instruction with no writes.
- Unlisted outputs default to 0 in each state.
- FETCH: adr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10. If ready: ir_write=1, pc_write=1, go to DECODE. Otherwise hold FETCH with no strobes.
- DECODE: src_a=01, src_b=01, alu_op=00 (branch target). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - anything else -> HALT if ILLEGAL_HALT, otherwise FETCH (no retire)
- MEMADR: src_a=10, src_b=01, alu_op=00. Next: MEMREAD for 0000011, MEMWRITE for 0100011.
- MEMREAD: adr_src=1, result_src=00. Hold until ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, retire=1, then FETCH.
- MEMWRITE: adr_src=1, mem_write=1 held every cycle until ready. Retire in the ready cycle, then FETCH.
- EXECR: src_a=10, src_b=00, alu_op=10, then ALUWB.
- EXECI: src_a=10, src_b=01, alu_op=10, then ALUWB.
- ALUWB: result_src=00, reg_write=1, retire=1, then FETCH.
- JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_write=1, then ALUWB.
- BEQ: src_a=10, src_b=00, alu_op=01, result_src=00, pc_write=w_alu_zero, retire=1, then FETCH.
- HALT: all strobes 0, halted=1. Sticky until reset.
- Latency with ready=1 every cycle: lw 5 cycles, sw 4, R/I-type 4, jal 4, beq 3. Each memory stall cycle adds 1.

Optional Feature:
MC_CTRL_PERF_CNT_EN defined:
- w_cycle_cnt increments every cycle with w_rst=0 and state != HALT.
- w_inst_cnt increments on w_retire.
- Both wrap modulo 2^CNT_W and clear on reset.
Not defined: both outputs are tied to 0 and no counter registers exist.

Test Plan:
- Reset, then lw (opcode 0000011), ready=1 -> states 0,1,2,3,4,0. reg_write and retire high only in cycle 5; ir_write and pc_write high only in cycle 1.
- sw (0100011), ready low 2 cycles in MEMWRITE -> mem_write high 3 consecutive cycles, single retire pulse on the third, then FETCH.
- beq (1100011): zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0 in BEQ. Both cases take 3 cycles and retire once.
- Opcode 1110011, ILLEGAL_HALT=1 -> HALT after DECODE, halted=1, no strobes for 10 cycles. Assert w_rst -> FETCH next edge, halted=0.
- w_rst asserted during a MEMWRITE stall -> mem_write=0 in the same cycle, state FETCH after the edge, no retire.
- With MC_CTRL_PERF_CNT_EN: after reset, add, addi and lw with ready=1 -> inst_cnt=3, cycle_cnt=13. Without the macro, both read 0.
